// File: rtl/updown_counter_param_if.sv
// Signal bundle between a counter user (master) and updown_counter_param (slave).
interface updown_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en_i;
  logic             load_i;
  logic [WIDTH-1:0] data_i;
  logic             up_down_i;
  logic             sat_mode_i;
  logic             clr_flag_i;
  logic [WIDTH-1:0] count_o;
  logic             tc_o;
  logic             roll_o;
  logic             ovf_o;
  logic             unf_o;

  modport master (
    output en_i, load_i, data_i, up_down_i, sat_mode_i, clr_flag_i,
    input  count_o, tc_o, roll_o, ovf_o, unf_o
  );

  modport slave (
    input  en_i, load_i, data_i, up_down_i, sat_mode_i, clr_flag_i,
    output count_o, tc_o, roll_o, ovf_o, unf_o
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus MAX_VAL, wrap/saturate modes,
// clamped load, terminal-count, rollover pulse and sticky over/underflow flags.
module updown_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int RST_VAL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  updown_counter_param_if.slave bus
);
  localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] data_ext_s;
  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;
  logic           at_max_s;
  logic           at_zero_s;

  assign count_ext_s = {1'b0, count_q};
  assign data_ext_s  = {1'b0, bus.data_i};
  assign inc_s       = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s       = count_ext_s - {{WIDTH{1'b0}}, 1'b1};
  assign at_max_s    = (count_ext_s == MAX_EXT);
  assign at_zero_s   = (count_q == {WIDTH{1'b0}});

  // Next-state: load beats count enable; flags clear unless set on the same edge.
  always_comb begin
    count_d = count_q;
    roll_d  = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_flag_i;
    unf_d   = unf_q & ~bus.clr_flag_i;
    if (bus.load_i) begin
      if (data_ext_s > MAX_EXT) begin
        count_d = MAX_CNT;
      end else begin
        count_d = bus.data_i;
      end
    end else if (bus.en_i) begin
      if (bus.up_down_i) begin
        if (at_max_s) begin
          roll_d  = 1'b1;
          ovf_d   = 1'b1;
          count_d = bus.sat_mode_i ? count_q : {WIDTH{1'b0}};
        end else begin
          count_d = inc_s[WIDTH-1:0];
        end
      end else begin
        if (at_zero_s) begin
          roll_d  = 1'b1;
          unf_d   = 1'b1;
          count_d = bus.sat_mode_i ? count_q : MAX_CNT;
        end else begin
          count_d = dec_s[WIDTH-1:0];
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_CNT;
      roll_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // tc looks ahead: the next enabled edge will be a boundary event.
  assign bus.tc_o    = bus.en_i & ((bus.up_down_i & at_max_s) | (~bus.up_down_i & at_zero_s));
  assign bus.count_o = count_q;
  assign bus.roll_o  = roll_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.unf_o   = unf_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: two counters (MAX_VAL 15 and 9) driven from a directed vector table.
module tb_updown_counter_param;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  updown_counter_param_if #(.WIDTH(4)) if_a ();
  updown_counter_param_if #(.WIDTH(4)) if_b ();

  updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         dut;
    bit         rst, en, load;
    logic [3:0] data;
    bit         ud, sat, clr;
    logic [3:0] cnt;
    bit         tc, roll, ovf, unf;
  } row_t;

  row_t rows[$];
  row_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string nm, input bit d, input bit rst, input bit en,
                     input bit ld, input int data, input bit ud, input bit sat,
                     input bit clr, input int cnt, input bit tc, input bit roll,
                     input bit ovf, input bit unf);
    row_t r;
    r.name = nm; r.dut = d; r.rst = rst; r.en = en; r.load = ld;
    r.data = data[3:0]; r.ud = ud; r.sat = sat; r.clr = clr;
    r.cnt = cnt[3:0]; r.tc = tc; r.roll = roll; r.ovf = ovf; r.unf = unf;
    rows.push_back(r);
  endtask

  task automatic chk(input string nm, input string fld, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, got, exp, $time);
    end
  endtask

  task automatic apply(input row_t r);
    reset = r.rst;
    if_a.en_i = 1'b0; if_a.load_i = 1'b0; if_a.data_i = 4'd0;
    if_a.up_down_i = 1'b0; if_a.sat_mode_i = 1'b0; if_a.clr_flag_i = 1'b0;
    if_b.en_i = 1'b0; if_b.load_i = 1'b0; if_b.data_i = 4'd0;
    if_b.up_down_i = 1'b0; if_b.sat_mode_i = 1'b0; if_b.clr_flag_i = 1'b0;
    if (r.dut == 1'b0) begin
      if_a.en_i = r.en; if_a.load_i = r.load; if_a.data_i = r.data;
      if_a.up_down_i = r.ud; if_a.sat_mode_i = r.sat; if_a.clr_flag_i = r.clr;
    end else begin
      if_b.en_i = r.en; if_b.load_i = r.load; if_b.data_i = r.data;
      if_b.up_down_i = r.ud; if_b.sat_mode_i = r.sat; if_b.clr_flag_i = r.clr;
    end
  endtask

  // Each row: inputs applied for the coming edge, and outputs expected while they are applied.
  initial begin
    //  name         d rst en ld data ud sat clr  cnt tc roll ovf unf
    add("reset",     0, 1, 0, 0,  0,  0, 0,  0,   0, 0, 0, 0, 0);
    add("load2",     0, 0, 0, 1,  2,  0, 0,  0,   0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++)
      add("count_up",0, 0, 1, 0,  0,  1, 0,  0, 2+i, 0, 0, 0, 0);
    add("at_max",    0, 0, 1, 0,  0,  1, 0,  0,  15, 1, 0, 0, 0);
    add("wrap",      0, 0, 0, 0,  0,  1, 0,  0,   0, 0, 1, 1, 0);
    add("roll_drop", 0, 0, 0, 1, 15,  0, 0,  0,   0, 0, 0, 1, 0);
    add("sat1",      0, 0, 1, 0,  0,  1, 1,  0,  15, 1, 0, 1, 0);
    add("sat2",      0, 0, 1, 0,  0,  1, 1,  0,  15, 1, 1, 1, 0);
    add("sat3",      0, 0, 1, 0,  0,  1, 1,  0,  15, 1, 1, 1, 0);
    add("clr",       0, 0, 0, 0,  0,  1, 1,  1,  15, 0, 1, 1, 0);
    add("cleared",   0, 0, 0, 0,  0,  0, 0,  0,  15, 0, 0, 0, 0);
    add("load5",     0, 0, 0, 1,  5,  0, 0,  0,  15, 0, 0, 0, 0);
    add("load_en",   0, 0, 1, 1,  7,  1, 0,  0,   5, 0, 0, 0, 0);
    add("load_wins", 0, 0, 0, 1, 15,  0, 0,  0,   7, 0, 0, 0, 0);
    add("pre_ovf",   0, 0, 1, 0,  0,  1, 0,  0,  15, 1, 0, 0, 0);
    add("set_clr",   0, 0, 1, 0,  0,  0, 0,  1,   0, 1, 1, 1, 0);
    add("set_wins",  0, 0, 0, 0,  0,  0, 0,  0,  15, 0, 1, 0, 1);
    add("load15",    0, 0, 0, 1, 15,  0, 0,  0,  15, 0, 0, 0, 1);
    add("up_max",    0, 0, 1, 0,  0,  1, 0,  0,  15, 1, 0, 0, 1);
    add("load11",    0, 0, 0, 1, 11,  0, 0,  0,   0, 0, 1, 1, 1);
    add("at11",      0, 0, 0, 0,  0,  0, 0,  0,  11, 0, 0, 1, 1);
    add("async_rst", 0, 1, 0, 0,  0,  0, 0,  0,   0, 0, 0, 0, 0);
    add("rst_rel",   0, 0, 1, 0,  0,  1, 0,  0,   0, 0, 0, 0, 0);
    add("from_rst",  0, 0, 0, 0,  0,  1, 0,  0,   1, 0, 0, 0, 0);
    add("b_clamp",   1, 0, 0, 1, 12,  0, 0,  0,   0, 0, 0, 0, 0);
    add("b_max",     1, 0, 1, 0,  0,  1, 0,  0,   9, 1, 0, 0, 0);
    add("b_load3",   1, 0, 0, 1,  3,  0, 0,  0,   0, 0, 1, 1, 0);
    add("b_dn3",     1, 0, 1, 0,  0,  0, 0,  0,   3, 0, 0, 1, 0);
    add("b_dn2",     1, 0, 1, 0,  0,  0, 0,  0,   2, 0, 0, 1, 0);
    add("b_dn1",     1, 0, 1, 0,  0,  0, 0,  0,   1, 0, 0, 1, 0);
    add("b_dn0",     1, 0, 1, 0,  0,  0, 0,  0,   0, 1, 0, 1, 0);
    add("b_wrap",    1, 0, 0, 0,  0,  0, 0,  0,   9, 0, 1, 1, 1);
    add("b_hold",    1, 0, 0, 0,  0,  0, 0,  0,   9, 0, 0, 1, 1);

    apply(rows[0]);
    @(posedge clk); #1;
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: sample away from the active edge and compare against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      row_t       e;
      logic [3:0] g_cnt;
      logic       g_tc, g_roll, g_ovf, g_unf;
      e = sb.pop_front();
      if (e.dut == 1'b0) begin
        g_cnt = if_a.count_o; g_tc = if_a.tc_o; g_roll = if_a.roll_o;
        g_ovf = if_a.ovf_o; g_unf = if_a.unf_o;
      end else begin
        g_cnt = if_b.count_o; g_tc = if_b.tc_o; g_roll = if_b.roll_o;
        g_ovf = if_b.ovf_o; g_unf = if_b.unf_o;
      end
      chk(e.name, "count", int'(g_cnt), int'(e.cnt));
      chk(e.name, "tc",    int'(g_tc),  int'(e.tc));
      chk(e.name, "roll",  int'(g_roll), int'(e.roll));
      chk(e.name, "ovf",   int'(g_ovf), int'(e.ovf));
      chk(e.name, "unf",   int'(g_unf), int'(e.unf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Single WIDTH-bit counter with configurable modulus (MAX_VAL), run-time direction, and run-time wrap/saturate mode.
- Adds synchronous load, count enable, a terminal-count flag, a one-cycle rollover pulse and a sticky overflow/underflow flag.
- Used as a generic event/timer counter in the verification course designs; drives status flags read by testbenches.

Parameters:
- WIDTH, 4: counter width in bits (≥2).
- MAX_VAL, 2**WIDTH-1: highest legal count; range is 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- RST_VAL, 0: count value on reset; must be ≤ MAX_VAL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; counter steps once per clk edge while high.
- load  input  1  synchronous load of data.
- data  input  WIDTH  load value.
- up_down  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
- clr_flag  input  1  synchronous clear of ovf and unf.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational (see Behaviour).
- roll  output  1  one-cycle pulse, registered, on a boundary event.
- ovf  output  1  sticky: an up-count was attempted at MAX_VAL.
- unf  output  1  sticky: a down-count was attempted at 0.

Behaviour:
- Reset (async, active-high): count = RST_VAL, roll = 0, ovf = 0, unf = 0, applied immediately and independent of clk. Reset release takes effect at the next clk edge.
- Per-edge priority: load > en > hold.
- load = 1:
  - count <= data, or MAX_VAL if data > MAX_VAL (clamped).
  - roll <= 0; the en and up_down inputs are ignored that cycle.
- load = 0, en = 1, up_down = 1:
  - If count < MAX_VAL: count <= count+1.
  - If count == MAX_VAL: boundary event. Wrap mode: count <= 0. Saturate mode: count holds MAX_VAL. Both modes: roll <= 1, ovf <= 1.
- load = 0, en = 1, up_down = 0:
  - If count > 0: count <= count-1.
  - If count == 0: boundary event. Wrap mode: count <= MAX_VAL. Saturate mode: count holds 0. Both modes: roll <= 1, unf <= 1.
- en = 0 and load = 0: count holds; roll <= 0.
- roll is high only in the cycle after a boundary event; consecutive boundary events (e.g. saturated and still enabled) keep roll high on each edge.
- tc = en & ((up_down & count==MAX_VAL) | (~up_down & count==0)). Combinational; tells the user the next enabled edge is a boundary event.
- clr_flag = 1 clears ovf and unf on that edge, unless a new event of the same kind occurs on the same edge; set wins.
- Arithmetic is done in WIDTH+1 bits internally. With a non-power-of-two MAX_VAL, count never leaves 0..MAX_VAL.
- up_down and sat_mode may change on any cycle and take effect at the next edge.
- Reset mid-count: the next edge after release starts from RST_VAL. Flags and roll are cleared.

Test Plan:
- WIDTH=4, MAX_VAL=15, wrap mode: load data=2, then up_down=1, en=1 for 13 edges -> count=15, tc=1. One more edge -> count=0, roll=1 for one cycle, ovf=1.
- Saturate mode, count=15, en=1, up_down=1 for 3 edges -> count stays 15, roll=1 on all 3 cycles, ovf=1. Then clr_flag=1 with en=0 -> ovf=0.
- MAX_VAL=9, load data=12 -> count=9 (clamped). Count down from 3 for 4 edges in wrap mode -> 2,1,0,9, with unf=1 after the 4th edge.
- Load and en in the same cycle: count=5, load=1, data=7, en=1, up_down=1 -> count=7 (not 8), roll=0.
- Assert reset asynchronously between clock edges at count=11 with ovf=1 -> count=RST_VAL, ovf=0, roll=0 immediately, before the next clk edge.
- Same-edge set vs clear: count=0, down, en=1, clr_flag=1 -> unf=1 (set wins), ovf=0.
